// File: rtl/pes_vector_pkg.sv
// Shared types and helpers for the serial-to-parallel vector feeder.
// Used by the deserializer and its inter-bit idle timer.
package pes_vector_pkg;

  localparam int VEC_WIDTH = 8;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  // Ceiling log2 with a floor of 1, so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/pes_idle_timer.sv
// Saturating idle-cycle counter. Its terminal count marks the TIMEOUT-th
// consecutive idle cycle; TIMEOUT = 0 means the terminal count never fires.
module pes_idle_timer
  import pes_vector_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int TW = clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TC_VAL  = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] MAX_VAL = '1;

  logic [TW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && count != MAX_VAL) begin
      count <= count + TW'(1);
    end
  end

  assign tc = (TIMEOUT != 0) && (count == TC_VAL);

endmodule

// File: rtl/pes_serial_deserializer.sv
// Framed serial-to-parallel deserializer feeding the vector-reversal stage.
// Completed words are registered and held; malformed frames raise frame_err.
module pes_serial_deserializer
  import pes_vector_pkg::*;
#(
  parameter int WIDTH     = VEC_WIDTH,
  parameter int MSB_FIRST = 1,
  parameter int TIMEOUT   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bit_in,
  input  logic                       bit_valid,
  input  logic                       sync_in,
  output logic [WIDTH-1:0]           out_vector,
  output logic                       vec_valid,
  output logic                       frame_err,
  output logic [clog2(WIDTH+1)-1:0]  bit_count
);

  localparam int CW = clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift_reg, shift_nxt, out_nxt;
  logic [CW-1:0]    count_nxt;
  logic             vec_nxt, err_nxt;
  logic             timer_clr, timer_en, timer_tc;

  // Places a new bit so that the first bit of a frame ends up at the MSB
  // (MSB_FIRST != 0) or at the LSB (MSB_FIRST == 0) once the word is full.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] word,
                                                input logic b);
    if (MSB_FIRST != 0) return {word[WIDTH-2:0], b};
    else                return {b, word[WIDTH-1:1]};
  endfunction

  pes_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk (clk),
    .rst (rst),
    .clr (timer_clr),
    .en  (timer_en),
    .tc  (timer_tc)
  );

  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    count_nxt = bit_count;
    out_nxt   = out_vector;
    vec_nxt   = 1'b0;
    err_nxt   = 1'b0;
    timer_clr = 1'b1;
    timer_en  = 1'b0;
    case (state)
      IDLE: begin
        if (bit_valid && sync_in) begin
          shift_nxt = shift_in('0, bit_in);
          count_nxt = CW'(1);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          // Re-sync wins over completion: the sync bit restarts the frame.
          if (sync_in) begin
            err_nxt   = 1'b1;
            shift_nxt = shift_in('0, bit_in);
            count_nxt = CW'(1);
          end else if (bit_count == CW'(WIDTH - 1)) begin
            out_nxt   = shift_in(shift_reg, bit_in);
            vec_nxt   = 1'b1;
            shift_nxt = '0;
            count_nxt = '0;
            state_nxt = IDLE;
          end else begin
            shift_nxt = shift_in(shift_reg, bit_in);
            count_nxt = bit_count + CW'(1);
          end
        end else if (timer_tc) begin
          err_nxt   = 1'b1;
          shift_nxt = '0;
          count_nxt = '0;
          state_nxt = IDLE;
        end else begin
          timer_clr = 1'b0;
          timer_en  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_count  <= '0;
      out_vector <= '0;
      vec_valid  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift_reg  <= shift_nxt;
      bit_count  <= count_nxt;
      out_vector <= out_nxt;
      vec_valid  <= vec_nxt;
      frame_err  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_pes_serial_deserializer.sv
// Directed bench: three deserializer variants (MSB-first/TIMEOUT=4,
// LSB-first/TIMEOUT=16, MSB-first/no timeout) share one serial stimulus.
module tb_pes_serial_deserializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bit_in = 1'b0, bit_valid = 1'b0, sync_in = 1'b0;

  logic [7:0] m_out, l_out, n_out;
  logic       m_vld, l_vld, n_vld;
  logic       m_err, l_err, n_err;
  logic [3:0] m_cnt, l_cnt, n_cnt;
  logic [7:0] rev_out;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  pes_serial_deserializer #(.WIDTH(8), .MSB_FIRST(1), .TIMEOUT(4)) u_msb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sync_in(sync_in),
    .out_vector(m_out), .vec_valid(m_vld), .frame_err(m_err), .bit_count(m_cnt));

  pes_serial_deserializer #(.WIDTH(8), .MSB_FIRST(0), .TIMEOUT(16)) u_lsb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sync_in(sync_in),
    .out_vector(l_out), .vec_valid(l_vld), .frame_err(l_err), .bit_count(l_cnt));

  pes_serial_deserializer #(.WIDTH(8), .MSB_FIRST(1), .TIMEOUT(0)) u_nto (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sync_in(sync_in),
    .out_vector(n_out), .vec_valid(n_vld), .frame_err(n_err), .bit_count(n_cnt));

  // Stand-in for the downstream registered reversal stage.
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) rev_out[i] <= m_out[7-i];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic b, input logic s);
    bit_valid = v;
    bit_in    = b;
    sync_in   = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bit_valid = 1'b0;
    sync_in   = 1'b0;
    bit_in    = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] w;
  logic       err_seen, vld_seen;

  initial begin
    #3;
    chk("rst_out", m_out, 8'h00);
    chk("rst_vld", m_vld, 1'b0);
    chk("rst_err", m_err, 1'b0);
    chk("rst_cnt", m_cnt, 4'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Gapless frame 1,0,1,1,0,0,1,0
    w = 8'hB2;
    for (int i = 7; i >= 1; i--) step(1'b1, w[i], i == 7);
    chk("pre_cnt", m_cnt, 4'd7);
    chk("pre_vld", m_vld, 1'b0);
    step(1'b1, w[0], 1'b0);
    chk("msb_word", m_out, 8'hB2);
    chk("msb_vld", m_vld, 1'b1);
    chk("msb_err", m_err, 1'b0);
    chk("msb_cnt", m_cnt, 4'd0);
    chk("lsb_word", l_out, 8'h4D);
    chk("lsb_vld", l_vld, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("vld_pulse", m_vld, 1'b0);
    chk("rev_word", rev_out, 8'h4D);

    // Same frame, three idle cycles before every bit after the sync
    err_seen = 1'b0;
    vld_seen = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (i != 7) begin
        repeat (3) begin
          step(1'b0, 1'b0, 1'b0);
          err_seen |= m_err | l_err;
        end
      end
      if (i == 6) chk("gap_cnt", m_cnt, 4'd1);
      if (i == 0) vld_seen = l_vld | m_vld;
      step(1'b1, w[i], i == 7);
      err_seen |= m_err | l_err;
    end
    chk("gap_prevld", vld_seen, 1'b0);
    chk("gap_lsb_word", l_out, 8'h4D);
    chk("gap_lsb_vld", l_vld, 1'b1);
    chk("gap_msb_vld", m_vld, 1'b1);
    chk("gap_no_err", err_seen, 1'b0);

    // Re-sync after four bits
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("rs_cnt4", m_cnt, 4'd4);
    step(1'b1, 1'b1, 1'b1);
    chk("rs_err", m_err, 1'b1);
    chk("rs_vld", m_vld, 1'b0);
    chk("rs_hold", m_out, 8'hB2);
    chk("rs_cnt1", m_cnt, 4'd1);
    w = 8'h8F;
    for (int i = 6; i >= 1; i--) step(1'b1, w[i], 1'b0);
    chk("rs_pre_vld", m_vld, 1'b0);
    chk("rs_err_pulse", m_err, 1'b0);
    step(1'b1, w[0], 1'b0);
    chk("rs_word", m_out, 8'h8F);
    chk("rs_vld2", m_vld, 1'b1);
    chk("rs_lsb_word", l_out, 8'hF1);

    // Re-sync on the final-bit position beats completion
    step(1'b1, 1'b0, 1'b1);
    repeat (6) step(1'b1, 1'b1, 1'b0);
    chk("rsf_cnt7", m_cnt, 4'd7);
    step(1'b1, 1'b1, 1'b1);
    chk("rsf_err", m_err, 1'b1);
    chk("rsf_vld", m_vld, 1'b0);
    chk("rsf_hold", m_out, 8'h8F);
    chk("rsf_cnt1", m_cnt, 4'd1);

    // Timeout of 4 idle cycles
    do_reset();
    chk("rst2_out", m_out, 8'h00);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    chk("to_err3", m_err, 1'b0);
    chk("to_cnt3", m_cnt, 4'd3);
    step(1'b0, 1'b0, 1'b0);
    chk("to_err4", m_err, 1'b1);
    chk("to_cnt4", m_cnt, 4'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("to_err_pulse", m_err, 1'b0);
    vld_seen = 1'b0;
    repeat (8) begin
      step(1'b1, 1'b1, 1'b0);
      vld_seen |= m_vld;
    end
    chk("to_nosync_vld", vld_seen, 1'b0);
    chk("to_nosync_cnt", m_cnt, 4'd0);

    // No timeout at all with TIMEOUT=0
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    err_seen = 1'b0;
    repeat (1000) begin
      step(1'b0, 1'b0, 1'b0);
      err_seen |= n_err;
    end
    chk("nto_err", err_seen, 1'b0);
    chk("nto_cnt", n_cnt, 4'd2);
    w = 8'hB2;
    for (int i = 5; i >= 0; i--) step(1'b1, w[i], 1'b0);
    chk("nto_word", n_out, 8'hB2);
    chk("nto_vld", n_vld, 1'b1);

    // Asynchronous reset mid-frame
    step(1'b1, 1'b1, 1'b1);
    repeat (4) step(1'b1, 1'b1, 1'b0);
    chk("ar_cnt5", n_cnt, 4'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_out", n_out, 8'h00);
    chk("ar_cnt", n_cnt, 4'd0);
    chk("ar_vld", n_vld, 1'b0);
    chk("ar_err", n_err, 1'b0);
    bit_valid = 1'b0;
    sync_in   = 1'b0;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ar_post_err", n_err, 1'b0);
    for (int i = 7; i >= 0; i--) step(1'b1, 1'b1, i == 7);
    chk("ff_word", n_out, 8'hFF);
    chk("ff_vld", n_vld, 1'b1);
    chk("ff_msb_word", m_out, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/pes_serial_deserializer.md
Name: pes_serial_deserializer

Overview:
- Upstream feeder for the 8-bit vector-reversal stage.
- Assembles a framed serial bit stream into a parallel word on out_vector.
- Holds the word stable between frames and flags each new word with a one-cycle vec_valid pulse.
- Detects malformed frames (early re-sync, inter-bit timeout), discards the partial word and reports frame_err.

Parameters:
- WIDTH, 8: word width in bits; legal range WIDTH >= 2.
- MSB_FIRST, 1: 1 = first received bit lands in out_vector[WIDTH-1]; 0 = first bit lands in out_vector[0].
- TIMEOUT, 16: consecutive bit_valid=0 cycles in SHIFT before abort; 0 disables timeout.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- bit_in  in  1  serial data bit; sampled only when bit_valid=1.
- bit_valid  in  1  qualifies bit_in this cycle.
- sync_in  in  1  start-of-frame marker; meaningful only with bit_valid=1; that bit is bit 0 of a frame.
- out_vector  out  WIDTH  last completed word; held until next completion.
- vec_valid  out  1  one-cycle pulse, concurrent with out_vector update.
- frame_err  out  1  one-cycle pulse on frame abort.
- bit_count  out  $clog2(WIDTH+1)  bits accumulated in the current frame.

Behaviour:
- Reset (async assert, sync release): state=IDLE, shift reg=0, bit_count=0, idle timer=0, out_vector=0, vec_valid=0, frame_err=0. Reset mid-frame discards the partial word, with no vec_valid and no frame_err.
- FSM states: IDLE, SHIFT.
- IDLE:
  - bit_valid & sync_in: capture bit as bit 0, bit_count=1, go SHIFT.
  - bit_valid without sync_in: ignored.
- SHIFT, bit_valid=1 & sync_in=0:
  - Shift bit in and increment bit_count; idle timer cleared.
  - Bit placement: MSB_FIRST=1 shifts left (new bit at LSB); MSB_FIRST=0 shifts right (new bit at MSB).
- SHIFT, bit_valid=1 & bit_count == WIDTH-1 (final bit):
  - On that edge, out_vector <= completed word and vec_valid=1 for exactly one cycle.
  - bit_count=0, go IDLE.
  - Next frame requires a new sync.
- SHIFT, bit_valid=1 & sync_in=1 (re-sync, including on the final-bit position):
  - frame_err pulses 1 cycle.
  - Partial word discarded; out_vector unchanged.
  - That bit becomes bit 0 of the new frame: bit_count=1, stay SHIFT.
- SHIFT, bit_valid=0:
  - Idle timer increments; state and data hold.
  - If TIMEOUT != 0 and timer == TIMEOUT-1, abort on this edge: frame_err pulse, bit_count=0, timer=0, go IDLE.
  - Abort therefore occurs on the edge of the TIMEOUT-th consecutive idle cycle.
- Precedence: bit_valid always overrides timeout in the same cycle; re-sync overrides completion.
- vec_valid and frame_err are never both 1 in the same cycle.
- Latency: a word is visible the cycle after the final-bit edge. The downstream reversal stage adds one more registered cycle.
- out_vector is registered. It never glitches and never changes except on completion or reset.

Decomposition:
- Shared package pes_vector_pkg:
  - VEC_WIDTH constant (8).
  - state enum {IDLE, SHIFT}.
  - Count width function clog2.
- One natural sub-module, pes_idle_timer:
  - Saturating counter with clear/enable inputs and a terminal-count output compared against TIMEOUT.
  - Instantiated once.

Test Plan:
- MSB_FIRST=1: sync with bit 1, then 0,1,1,0,0,1,0 on consecutive cycles -> out_vector=8'hB2 and vec_valid=1 for one cycle, the cycle after the 8th bit; downstream reversed output =8'h4D one cycle later.
- MSB_FIRST=0, same bit sequence -> out_vector=8'h4D; then with TIMEOUT=16 and 3 idle cycles between every bit -> same 8'h4D, frame_err never asserted.
- After a completed frame of 8'hB2: sync at bit 0, 4 bits, then sync again -> frame_err pulse; out_vector stays 8'hB2; next 7 bits complete a new word from the second sync.
- TIMEOUT=4: sync + 2 bits, then 4 idle cycles -> frame_err on the 4th idle edge, bit_count=0, IDLE. Subsequent 8 bits without sync -> no vec_valid.
- TIMEOUT=4: 3 idle cycles, then bit_valid on the 4th -> no abort, frame continues. Also TIMEOUT=0 with 1000 idle cycles -> no abort.
- rst asserted asynchronously between clock edges after bit 5 -> out_vector, vec_valid, frame_err and bit_count go 0 immediately. After release, a fresh full frame 8'hFF -> out_vector=8'hFF.
